// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response channels of the ALU arbiter.
// The "slave" modport is the arbiter's view; "master" is the surrounding
// system (requesters, the combinational ALU and the response consumer).
interface alu_arbiter_if #(
    parameter int BW   = 16,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    // Request channel, one slot per requester (packed by requester index)
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*3-1:0]    req_opcode;
    logic [NREQ*BW-1:0]   req_a;
    logic [NREQ*BW-1:0]   req_b;
    logic [NREQ-1:0]      req_lock;

    // ALU side: operands out, result and {overflow,negative,zero} back
    logic [BW-1:0]        alu_a;
    logic [BW-1:0]        alu_b;
    logic [2:0]           alu_opcode;
    logic [BW-1:0]        alu_out;
    logic [2:0]           alu_flags;

    // Tagged response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [BW-1:0]        rsp_data;
    logic [2:0]           rsp_flags;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_lock,
        input  alu_out, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode,
        output rsp_valid, rsp_id, rsp_data, rsp_flags
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_lock,
        output alu_out, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters.
// Round-robin grant into an issue register that drives the ALU, then a
// response register that captures the ALU result with the requester id.
// Optional feature macro: ALU_ARB_LOCK_EN (grant lock for atomic sequences).
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. Senders hold valid and payload stable
// until the transfer; ready may depend combinationally on valid, so a sender
// must never derive its valid from ready.
module alu_arbiter #(
    parameter int BW   = 16,
    parameter int NREQ = 4
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // Issue stage (drives the ALU)
    logic           iss_valid;
    logic [IDW-1:0] iss_id;
    logic [2:0]     iss_op;
    logic [BW-1:0]  iss_a;
    logic [BW-1:0]  iss_b;

    // Response stage
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [BW-1:0]  rsp_data_q;
    logic [2:0]     rsp_flags_q;

    // Last granted requester; the search starts one past it
    logic [IDW-1:0] ptr;

    logic           adv_rsp;
    logic           adv_iss;
    logic [NREQ-1:0] eligible;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic           handshake;

    // Response stage may load when empty or being drained; the issue stage
    // may load when empty or when its op can move on this same edge.
    assign adv_rsp   = !rsp_valid_q || bus.rsp_ready;
    assign adv_iss   = !iss_valid || adv_rsp;
    assign handshake = adv_iss && grant_found;

`ifdef ALU_ARB_LOCK_EN
    logic           locked;
    logic [IDW-1:0] lock_id;

    // While a lock is held only the owner can be considered for a grant
    always_comb begin
        eligible = bus.req_valid;
        if (locked) begin
            eligible          = '0;
            eligible[lock_id] = bus.req_valid[lock_id];
        end
    end

    // Every accepted op sets or clears the lock according to its req_lock bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (handshake) begin
            locked  <= bus.req_lock[grant_id];
            lock_id <= grant_id;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign eligible    = bus.req_valid;
`endif

    // Round-robin search: first eligible requester after ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // One-hot accept toward the winner, only when the issue stage can load
    always_comb begin
        bus.req_ready = '0;
        if (!rst && handshake) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Issue register: captures the granted op; holds contents when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_op    <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
            ptr       <= LAST_ID;
        end else if (adv_iss) begin
            iss_valid <= grant_found;
            if (grant_found) begin
                iss_id <= grant_id;
                iss_op <= bus.req_opcode[3*grant_id +: 3];
                iss_a  <= bus.req_a[BW*grant_id +: BW];
                iss_b  <= bus.req_b[BW*grant_id +: BW];
                ptr    <= grant_id;
            end
        end
    end

    // Response register: takes the ALU result of the op in the issue stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else if (adv_rsp) begin
            rsp_valid_q <= iss_valid;
            if (iss_valid) begin
                rsp_id_q    <= iss_id;
                rsp_data_q  <= bus.alu_out;
                rsp_flags_q <= bus.alu_flags;
            end
        end
    end

    assign bus.alu_a      = iss_a;
    assign bus.alu_b      = iss_b;
    assign bus.alu_opcode = iss_op;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flags  = rsp_flags_q;
endmodule
